// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: consumer side of the timer interrupt line.
// Owns mtimecmp, qualifies timer_interrupt with enables and a post-write guard,
// and runs the trap request/acknowledge handshake into the core pipeline.
// Optional build macro: TIMER_IRQ_COUNT_EN adds a 16-bit accepted-trap counter
// that is read at status[31:16] and cleared by a status write.
module timer_irq_ctrl #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_interrupt,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [31:0] mtimecmp,
  input  logic [31:0] pc_in,
  output logic        trap_req,
  input  logic        trap_ack,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc,
  input  logic        mret,
  output logic        in_handler
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  ctrl;    // bit0 MTIE, bit1 GIE
  logic [1:0]  guard;   // masks the stale level while the timer's compare catches up
  logic [15:0] trap_cnt;
  logic        pend;
  logic        we_cmp, we_ctrl, we_mepc;
  logic        accept;

  assign we_cmp  = csr_we && (csr_addr == 2'd0);
  assign we_ctrl = csr_we && (csr_addr == 2'd1);
  assign we_mepc = csr_we && (csr_addr == 2'd2);

  assign pend        = timer_interrupt && (guard == 2'd0);
  assign accept      = (state == REQ) && trap_ack;
  assign trap_req    = (state == REQ);
  assign in_handler  = (state == HANDLER);
  assign trap_vector = TRAP_VECTOR;

  // Trap handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a request, once raised, is committed until the pipeline acks it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend && ctrl[0] && ctrl[1]) state_nxt = REQ;
      REQ:     if (trap_ack)                   state_nxt = HANDLER;
      HANDLER: if (mret)                       state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // CSR registers; a trap capture takes priority over a software mepc write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtimecmp <= MTIMECMP_RST;
      ctrl     <= 2'b00;
      mepc     <= 32'h0;
    end else begin
      if (we_cmp)  mtimecmp <= csr_wdata;
      if (we_ctrl) ctrl     <= csr_wdata[1:0];
      if (accept)       mepc <= pc_in;
      else if (we_mepc) mepc <= csr_wdata;
    end
  end

  // Guard reloads on every mtimecmp write and counts down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              guard <= 2'd0;
    else if (we_cmp)        guard <= 2'd2;
    else if (guard != 2'd0) guard <= guard - 2'd1;
  end

`ifdef TIMER_IRQ_COUNT_EN
  logic we_status;
  assign we_status = csr_we && (csr_addr == 2'd3);

  // Accepted-trap counter; wraps naturally, status write clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          trap_cnt <= 16'h0;
    else if (we_status) trap_cnt <= 16'h0;
    else if (accept)    trap_cnt <= trap_cnt + 16'h1;
  end
`else
  assign trap_cnt = 16'h0;
`endif

  // Combinational CSR read mux.
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      2'd0: csr_rdata = mtimecmp;
      2'd1: csr_rdata = {30'h0, ctrl};
      2'd2: csr_rdata = mepc;
      2'd3: csr_rdata = {trap_cnt, 12'h0, in_handler, state, pend};
      default: csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl. Inputs change 1ns after the rising edge,
// outputs are compared at the same point (well clear of the next edge).
module tb_timer_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        timer_interrupt = 1'b0;
  logic        csr_we = 1'b0;
  logic [1:0]  csr_addr = 2'd0;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic [31:0] mtimecmp;
  logic [31:0] pc_in = 32'h0;
  logic        trap_req;
  logic        trap_ack = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] mepc;
  logic        mret = 1'b0;
  logic        in_handler;

  int errs = 0;
  int chks = 0;
  logic [15:0] cnt_exp;

  timer_irq_ctrl dut (
    .clk(clk), .reset(reset), .timer_interrupt(timer_interrupt),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .mtimecmp(mtimecmp), .pc_in(pc_in),
    .trap_req(trap_req), .trap_ack(trap_ack), .trap_vector(trap_vector),
    .mepc(mepc), .mret(mret), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_trap_req", {31'h0, trap_req}, 32'h0);
    chk("rst_in_handler", {31'h0, in_handler}, 32'h0);
    reset = 1'b0;
    step();
    rd(2'd0, d); chk("rst_mtimecmp", d, 32'hFFFF_FFFF);
    rd(2'd1, d); chk("rst_ctrl", d, 32'h0);
    rd(2'd2, d); chk("rst_mepc", d, 32'h0);
    rd(2'd3, d); chk("rst_status", d, 32'h0);
    chk("trap_vector", trap_vector, 32'h0000_0100);

    // first trap: enable, raise level, ack 3 cycles after request
    wr(2'd1, 32'h3);
    rd(2'd1, d); chk("ctrl_3", d, 32'h3);
    pc_in = 32'h40;
    timer_interrupt = 1'b1;
    #1 chk("req_not_yet", {31'h0, trap_req}, 32'h0);
    step(); chk("req_rise", {31'h0, trap_req}, 32'h1);
    step(); chk("req_hold1", {31'h0, trap_req}, 32'h1);
    step(); chk("req_hold2", {31'h0, trap_req}, 32'h1);
    trap_ack = 1'b1;
    step(); trap_ack = 1'b0;
    chk("ack_req_low", {31'h0, trap_req}, 32'h0);
    chk("ack_in_handler", {31'h0, in_handler}, 32'h1);
    chk("ack_mepc", mepc, 32'h40);
    rd(2'd3, d); chk("status_handler", {30'h0, d[2:1]}, 32'h2);

    // level held in handler: no nesting
    for (int i = 0; i < 20; i++) begin
      step(); chk("no_nest", {31'h0, trap_req}, 32'h0);
    end
    mret = 1'b1;
    step(); mret = 1'b0;
    chk("mret_idle", {31'h0, in_handler}, 32'h0);
    chk("mret_no_req_yet", {31'h0, trap_req}, 32'h0);
    step(); chk("retrap", {31'h0, trap_req}, 32'h1);
    pc_in = 32'h80; trap_ack = 1'b1;
    step(); trap_ack = 1'b0;
    chk("retrap_mepc", mepc, 32'h80);
    chk("retrap_handler", {31'h0, in_handler}, 32'h1);

    // mtimecmp write in handler; guard masks the lagging level
    wr(2'd0, 32'h0000_1000);
    chk("mtimecmp_out", mtimecmp, 32'h0000_1000);
    rd(2'd3, d); chk("guard_pend0", d, 32'h0000_000C);
    mret = 1'b1;
    step(); mret = 1'b0;
    rd(2'd3, d); chk("guard_idle_status", d, 32'h0);
    chk("guard_no_req_a", {31'h0, trap_req}, 32'h0);
    timer_interrupt = 1'b0;
    step(); chk("guard_no_req_b", {31'h0, trap_req}, 32'h0);
    step(); chk("guard_no_req_c", {31'h0, trap_req}, 32'h0);

    // committed request survives enable clear and level drop; reset kills it
    timer_interrupt = 1'b1;
    step(); chk("req3_rise", {31'h0, trap_req}, 32'h1);
    timer_interrupt = 1'b0;
    wr(2'd1, 32'h0);
    chk("req3_held_a", {31'h0, trap_req}, 32'h1);
    rd(2'd1, d); chk("ctrl_cleared", d, 32'h0);
    step(); chk("req3_held_b", {31'h0, trap_req}, 32'h1);
    reset = 1'b1;
    #1 chk("reset_req_drop", {31'h0, trap_req}, 32'h0);
    rd(2'd3, d); chk("reset_status", d, 32'h0);
    chk("reset_mepc", mepc, 32'h0);
    chk("reset_mtimecmp", mtimecmp, 32'hFFFF_FFFF);
    step(); reset = 1'b0;

    // CSR write corner cases
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("status_wr_ignored", d, 32'h0);
    wr(2'd1, 32'hFFFF_FFFE);
    rd(2'd1, d); chk("ctrl_mask", d, 32'h2);
    wr(2'd2, 32'h0000_1234);
    rd(2'd2, d); chk("mepc_sw_write", d, 32'h0000_1234);
    wr(2'd1, 32'hFFFF_FFFF);
    timer_interrupt = 1'b1;
    step(); chk("req4_rise", {31'h0, trap_req}, 32'h1);
    trap_ack = 1'b1; pc_in = 32'h200;
    csr_we = 1'b1; csr_addr = 2'd2; csr_wdata = 32'h0000_DEAD;
    step(); trap_ack = 1'b0; csr_we = 1'b0;
    chk("ack_overrides_csr", mepc, 32'h200);
    timer_interrupt = 1'b0;
    trap_ack = 1'b1; pc_in = 32'h300;
    step(); trap_ack = 1'b0;
    chk("ack_ignored_handler", mepc, 32'h200);
    chk("still_handler", {31'h0, in_handler}, 32'h1);
    mret = 1'b1;
    step();
    chk("mret_exit", {31'h0, in_handler}, 32'h0);
    step(); mret = 1'b0;
    rd(2'd3, d); chk("mret_idle_ignored", d[15:0], 32'h0);

    // trap counter: clear, take 5 traps, then clear again
    wr(2'd3, 32'h0);
    timer_interrupt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      trap_ack = 1'b1;
      step(); trap_ack = 1'b0; mret = 1'b1;
      step(); mret = 1'b0;
    end
    timer_interrupt = 1'b0;
`ifdef TIMER_IRQ_COUNT_EN
    cnt_exp = 16'd5;
`else
    cnt_exp = 16'd0;
`endif
    rd(2'd3, d); chk("trap_count", d, {cnt_exp, 16'h0});
    wr(2'd3, 32'h0);
    rd(2'd3, d); chk("trap_count_clr", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
